reorder_buffer_scheduler: RTL and testbench
===========================================

Name: reorder_buffer_scheduler

Overview:
- Shares one valid/ready reorder buffer between REQUESTERS independent requesters.
- Front side: round-robin arbitration of requesters onto the buffer's single reservation port; the granted requester receives the reserved index as its tag.
- Back side: an internal owner FIFO records which requester holds each reservation, and in-order read data from the buffer is steered back to that requester.
- Sits between requester agents and the reorder buffer; the buffer's write port is driven by the out-of-order responders, not by this block.

Parameters:
- WIDTH, 8, data width of the reorder buffer.
- DEPTH, 8, reorder buffer depth; also the owner FIFO depth.
- INDEX_WIDTH, $clog2(DEPTH), reservation index width.
- REQUESTERS, 4, number of requesters, minimum 2.
- ID_WIDTH, $clog2(REQUESTERS), requester identifier width.
- QUOTA, 2, maximum outstanding reservations per requester; used only with the optional feature.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- request_valid  in  REQUESTERS  per-requester reservation request.
- request_ready  out  REQUESTERS  per-requester grant; handshake completes the reservation.
- request_index  out  INDEX_WIDTH  reserved index, broadcast to all requesters; valid with request_ready.
- response_valid  out  REQUESTERS  in-order data available for the owning requester.
- response_data  out  WIDTH  read data, broadcast to all requesters.
- response_ready  in  REQUESTERS  per-requester accept.
- rob_reserve_valid  out  1  to reorder buffer reserve_valid.
- rob_reserve_index  in  INDEX_WIDTH  from reorder buffer reserve_index.
- rob_reserve_ready  in  1  from reorder buffer reserve_ready.
- rob_read_valid  in  1  from reorder buffer read_valid.
- rob_read_data  in  WIDTH  from reorder buffer read_data.
- rob_read_ready  out  1  to reorder buffer read_ready.
- outstanding  out  INDEX_WIDTH+1  number of entries in the owner FIFO.
- owner_error  out  1  sticky flag: rob_read_valid seen while the owner FIFO is empty.

Behaviour:
- Reset: owner FIFO emptied; outstanding=0; round-robin pointer=0 (requester 0 has top priority); owner_error=0.
  - All request_ready and response_valid are 0 while reset is high.
  - The reorder buffer must be reset in the same cycle; resetting mid-operation discards every reservation and owner record.
- Eligible set = request_valid & ~masked; masked is all-zero without the optional feature.
- Grant: the first eligible requester at or after the pointer, wrapping modulo REQUESTERS. Selection is combinational and at most one requester is granted per cycle.
- rob_reserve_valid = (eligible set non-empty) & ~owner_full.
  - It must not depend on rob_reserve_ready.
- request_ready[i] = grant[i] & rob_reserve_ready & ~owner_full.
- request_index = rob_reserve_index, combinational, zero latency.
- On a reservation handshake:
  - push the granted ID into the owner FIFO;
  - pointer <= (granted ID + 1) mod REQUESTERS.
- Without a handshake the pointer holds, so a stalled grant stays on the same requester.
- Head owner = owner FIFO head ID.
- response_valid[i] = rob_read_valid & ~owner_empty & (head owner == i).
- rob_read_ready = ~owner_empty & response_ready[head owner].
  - A ready from a non-owner has no effect.
- response_data = rob_read_data, combinational.
- On a read handshake the owner FIFO is popped.
- Simultaneous push and pop: outstanding is unchanged, and the push is still refused when the FIFO is full at the start of the cycle. There is no full-bypass; full and empty are registered-state based.
- Owner FIFO pointers have one extra wrap bit; full = same index with opposite wrap bits.
- owner_error is set when rob_read_valid=1 and owner_empty=1, and cleared only by reset. No pop occurs in that case.
- Response latency is 0 cycles from rob_read_valid. Reservation latency is 0 cycles from request_valid when not stalled.

Optional Feature:
- Macro: REORDER_BUFFER_SCHEDULER_QUOTA_EN.
- Defined:
  - Each requester has a counter of width $clog2(QUOTA+1), reset to 0.
  - The counter increments on that requester's reservation handshake and decrements on its read handshake; a simultaneous increment and decrement leaves it unchanged.
  - masked[i] = (counter[i] == QUOTA). A masked requester is skipped by arbitration and its request_ready is 0.
- Undefined: no counters exist, masked = 0, and QUOTA is ignored.

Test Plan:
- Requesters 0-3 valid continuously, rob_reserve_ready=1, DEPTH=8 → grants in order 0,1,2,3,0,1,2,3; request_index 0..7; outstanding reaches 8; all request_ready drop while full.
- Requester 2 valid with rob_reserve_ready=0 for 3 cycles, then requester 0 also becomes valid → grant stays on 2 until the handshake; next grant goes to 0.
- Reserve order 1,3,1; rob_read_valid=1 with response_ready all-ones → response_valid asserted one-hot 1, 3, 1 on consecutive cycles; outstanding returns to 0.
- Head owner 3 with response_ready=4'b0111 → rob_read_ready=0 and the FIFO holds; setting response_ready[3]=1 completes the pop.
- Reservation and read handshakes in the same cycle at outstanding=5 → outstanding stays 5. At outstanding=8 with a read, the reserve is refused that cycle and accepted the next.
- QUOTA_EN, QUOTA=2: requester 0 alone reserves twice, third request_ready=0 while requester 1 is still granted; after one read for requester 0, it is granted again. Reset asserted mid-run → outstanding=0, owner_error=0, and requester 0 is granted first.

Source files
------------

// File: rtl/reorder_buffer_scheduler.sv
// rtl/reorder_buffer_scheduler.sv - round-robin reservation front end and owner-steered in-order return for a shared reorder buffer
// Optional per-requester outstanding quota: define REORDER_BUFFER_SCHEDULER_QUOTA_EN
module reorder_buffer_scheduler #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = $clog2(DEPTH),
  parameter int REQUESTERS  = 4,
  parameter int ID_WIDTH    = $clog2(REQUESTERS),
  parameter int QUOTA       = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [REQUESTERS-1:0]   request_valid,
  output logic [REQUESTERS-1:0]   request_ready,
  output logic [INDEX_WIDTH-1:0]  request_index,
  output logic [REQUESTERS-1:0]   response_valid,
  output logic [WIDTH-1:0]        response_data,
  input  logic [REQUESTERS-1:0]   response_ready,
  output logic                    rob_reserve_valid,
  input  logic [INDEX_WIDTH-1:0]  rob_reserve_index,
  input  logic                    rob_reserve_ready,
  input  logic                    rob_read_valid,
  input  logic [WIDTH-1:0]        rob_read_data,
  output logic                    rob_read_ready,
  output logic [INDEX_WIDTH:0]    outstanding,
  output logic                    owner_error
);

  if (REQUESTERS < 2) begin : g_bad_requesters
    $error("reorder_buffer_scheduler needs at least two requesters");
  end
  if (QUOTA < 1) begin : g_bad_quota
    $error("reorder_buffer_scheduler quota must be at least one");
  end

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(REQUESTERS - 1);

  // owner FIFO: one requester ID per live reservation, in reservation order
  logic [ID_WIDTH-1:0]    owner_mem [DEPTH];
  logic [INDEX_WIDTH:0]   write_ptr;
  logic [INDEX_WIDTH:0]   read_ptr;
  logic                   owner_empty;
  logic                   owner_full;
  logic [ID_WIDTH-1:0]    head_owner;

  logic [ID_WIDTH-1:0]    rr_ptr;
  logic [ID_WIDTH-1:0]    grant_id;
  logic                   grant_found;
  logic [REQUESTERS-1:0]  grant;
  logic [REQUESTERS-1:0]  masked;
  logic [REQUESTERS-1:0]  eligible;
  logic                   reserve_fire;
  logic                   read_fire;

  assign owner_empty = (write_ptr == read_ptr);
  assign owner_full  = (write_ptr[INDEX_WIDTH-1:0] == read_ptr[INDEX_WIDTH-1:0]) &&
                       (write_ptr[INDEX_WIDTH] != read_ptr[INDEX_WIDTH]);
  assign outstanding = write_ptr - read_ptr;
  assign head_owner  = owner_mem[read_ptr[INDEX_WIDTH-1:0]];

  assign eligible = request_valid & ~masked;

  // first eligible requester at or after the round-robin pointer, wrapping
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    grant       = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = (int'(rr_ptr) + k) % REQUESTERS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_WIDTH'(idx);
      end
    end
    grant[grant_id] = grant_found;
  end

  // reserve_valid deliberately ignores rob_reserve_ready to avoid a combinational loop
  assign rob_reserve_valid = ~reset & grant_found & ~owner_full;
  assign request_ready     = grant & {REQUESTERS{~reset & rob_reserve_ready & ~owner_full}};
  assign request_index     = rob_reserve_index;
  assign reserve_fire      = rob_reserve_valid & rob_reserve_ready;

  // steer in-order read data to whoever owns the FIFO head
  always_comb begin
    response_valid = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      response_valid[i] = ~reset & rob_read_valid & ~owner_empty & (head_owner == ID_WIDTH'(i));
    end
  end

  assign rob_read_ready = ~reset & ~owner_empty & response_ready[head_owner];
  assign response_data  = rob_read_data;
  assign read_fire      = rob_read_valid & rob_read_ready;

  // owner FIFO pointers and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (reserve_fire) begin
        write_ptr <= write_ptr + 1'b1;
        rr_ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
      if (read_fire) begin
        read_ptr <= read_ptr + 1'b1;
      end
    end
  end

  // owner storage; stale entries are unreachable after reset so no clear is needed
  always_ff @(posedge clock) begin
    if (reserve_fire) begin
      owner_mem[write_ptr[INDEX_WIDTH-1:0]] <= grant_id;
    end
  end

  // sticky flag for read data arriving with no recorded owner
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_error <= 1'b0;
    end else if (rob_read_valid && owner_empty) begin
      owner_error <= 1'b1;
    end
  end

`ifdef REORDER_BUFFER_SCHEDULER_QUOTA_EN
  localparam int COUNT_WIDTH = $clog2(QUOTA + 1);

  logic [COUNT_WIDTH-1:0] quota_count [REQUESTERS];
  logic [REQUESTERS-1:0]  reserve_by;
  logic [REQUESTERS-1:0]  read_by;

  // which requester gains or returns a reservation this cycle
  always_comb begin
    reserve_by = '0;
    read_by    = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      reserve_by[i] = reserve_fire & grant[i];
      read_by[i]    = read_fire & (head_owner == ID_WIDTH'(i));
    end
  end

  // per-requester outstanding counters; simultaneous gain and return cancel
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        quota_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (reserve_by[i] && !read_by[i]) begin
          quota_count[i] <= quota_count[i] + 1'b1;
        end else if (read_by[i] && !reserve_by[i]) begin
          quota_count[i] <= quota_count[i] - 1'b1;
        end
      end
    end
  end

  // a requester at its quota drops out of arbitration
  always_comb begin
    masked = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      masked[i] = (quota_count[i] == COUNT_WIDTH'(QUOTA));
    end
  end
`else
  assign masked = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer_scheduler.sv
// tb/tb_reorder_buffer_scheduler.sv - directed self-checking bench for reorder_buffer_scheduler
module tb_reorder_buffer_scheduler;
  localparam int WIDTH       = 8;
  localparam int DEPTH       = 8;
  localparam int INDEX_WIDTH = 3;
  localparam int REQUESTERS  = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [REQUESTERS-1:0]  request_valid;
  logic [REQUESTERS-1:0]  request_ready;
  logic [INDEX_WIDTH-1:0] request_index;
  logic [REQUESTERS-1:0]  response_valid;
  logic [WIDTH-1:0]       response_data;
  logic [REQUESTERS-1:0]  response_ready;
  logic                   rob_reserve_valid;
  logic [INDEX_WIDTH-1:0] rob_reserve_index;
  logic                   rob_reserve_ready;
  logic                   rob_read_valid;
  logic [WIDTH-1:0]       rob_read_data;
  logic                   rob_read_ready;
  logic [INDEX_WIDTH:0]   outstanding;
  logic                   owner_error;

  logic [INDEX_WIDTH-1:0] rob_idx = '0;
  int checks = 0;
  int fails  = 0;

  assign rob_reserve_index = rob_idx;

  reorder_buffer_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .REQUESTERS(REQUESTERS), .QUOTA(2)
  ) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready), .request_index(request_index),
    .response_valid(response_valid), .response_data(response_data), .response_ready(response_ready),
    .rob_reserve_valid(rob_reserve_valid), .rob_reserve_index(rob_reserve_index),
    .rob_reserve_ready(rob_reserve_ready), .rob_read_valid(rob_read_valid),
    .rob_read_data(rob_read_data), .rob_read_ready(rob_read_ready),
    .outstanding(outstanding), .owner_error(owner_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // advance one cycle; the reorder buffer model hands out indices in order
  task automatic tick();
    logic fire;
    fire = rob_reserve_valid && rob_reserve_ready && !reset;
    @(posedge clock);
    #1;
    if (reset) rob_idx = '0;
    else if (fire) rob_idx = rob_idx + 1'b1;
  endtask

  task automatic idle();
    request_valid     = '0;
    response_ready    = '0;
    rob_reserve_ready = 1'b0;
    rob_read_valid    = 1'b0;
    rob_read_data     = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; request_valid = '1; rob_reserve_ready = 1'b1;
    rob_read_valid = 1'b1; response_ready = '1; rob_read_data = 8'h55;
    #1;
    checks++; if (request_ready !== 4'b0000) begin fails++; $display("FAIL reset_request_ready: got %b want %b", request_ready, 4'b0000); end
    checks++; if (response_valid !== 4'b0000) begin fails++; $display("FAIL reset_response_valid: got %b want %b", response_valid, 4'b0000); end
    tick(); tick();
    reset = 1'b0; idle();
    #1;
    checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (owner_error !== 1'b0) begin fails++; $display("FAIL reset_owner_error: got %b want 0", owner_error); end
    checks++; if (rob_read_ready !== 1'b0) begin fails++; $display("FAIL reset_read_ready: got %b want 0", rob_read_ready); end
  endtask

  task automatic test_fill_and_drain();
    logic [3:0] exp;
    logic [7:0] dat;
    request_valid = 4'hF; rob_reserve_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp = 4'b0001 << (c % 4);
      checks++; if (request_ready !== exp) begin fails++; $display("FAIL fill_grant[%0d]: got %b want %b", c, request_ready, exp); end
      checks++; if (request_index !== 3'(c)) begin fails++; $display("FAIL fill_index[%0d]: got %0d want %0d", c, request_index, c); end
      checks++; if (outstanding !== 4'(c)) begin fails++; $display("FAIL fill_outstanding[%0d]: got %0d want %0d", c, outstanding, c); end
      tick();
    end
    #1;
    checks++; if (outstanding !== 4'd8) begin fails++; $display("FAIL full_outstanding: got %0d want 8", outstanding); end
    checks++; if (request_ready !== 4'b0000) begin fails++; $display("FAIL full_request_ready: got %b want 0000", request_ready); end
    checks++; if (rob_reserve_valid !== 1'b0) begin fails++; $display("FAIL full_reserve_valid: got %b want 0", rob_reserve_valid); end
    request_valid = '0; rob_read_valid = 1'b1; response_ready = '1;
    for (int c = 0; c < 8; c++) begin
      dat = 8'hA0 + 8'(c);
      rob_read_data = dat;
      #1;
      exp = 4'b0001 << (c % 4);
      checks++; if (response_valid !== exp) begin fails++; $display("FAIL drain_owner[%0d]: got %b want %b", c, response_valid, exp); end
      checks++; if (response_data !== dat) begin fails++; $display("FAIL drain_data[%0d]: got %h want %h", c, response_data, dat); end
      tick();
    end
    idle(); #1;
    checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL drain_outstanding: got %0d want 0", outstanding); end
  endtask

  task automatic test_stalled_grant();
    request_valid = 4'b0001; rob_reserve_ready = 1'b1; #1;
    checks++; if (request_ready !== 4'b0001) begin fails++; $display("FAIL stall_setup: got %b want 0001", request_ready); end
    tick();
    request_valid = '0; rob_read_valid = 1'b1; response_ready = '1; #1;
    checks++; if (response_valid !== 4'b0001) begin fails++; $display("FAIL stall_setup_read: got %b want 0001", response_valid); end
    tick(); idle();
    request_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rob_reserve_valid !== 1'b1) begin fails++; $display("FAIL stall_reserve_valid[%0d]: got %b want 1", c, rob_reserve_valid); end
      checks++; if (request_ready !== 4'b0000) begin fails++; $display("FAIL stall_request_ready[%0d]: got %b want 0000", c, request_ready); end
      tick();
    end
    request_valid = 4'b0101; #1;
    checks++; if (rob_reserve_valid !== 1'b1) begin fails++; $display("FAIL stall_both_valid: got %b want 1", rob_reserve_valid); end
    tick();
    rob_reserve_ready = 1'b1; #1;
    checks++; if (request_ready !== 4'b0100) begin fails++; $display("FAIL stall_held_grant: got %b want 0100", request_ready); end
    tick(); #1;
    checks++; if (request_ready !== 4'b0001) begin fails++; $display("FAIL stall_next_grant: got %b want 0001", request_ready); end
    tick();
    idle(); rob_read_valid = 1'b1; response_ready = '1; #1;
    checks++; if (response_valid !== 4'b0100) begin fails++; $display("FAIL stall_read0: got %b want 0100", response_valid); end
    tick(); #1;
    checks++; if (response_valid !== 4'b0001) begin fails++; $display("FAIL stall_read1: got %b want 0001", response_valid); end
    tick(); idle();
  endtask

  task automatic test_in_order_response();
    logic [3:0] order [3];
    order[0] = 4'b0010; order[1] = 4'b1000; order[2] = 4'b0010;
    rob_reserve_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      request_valid = order[c]; #1;
      checks++; if (request_ready !== order[c]) begin fails++; $display("FAIL order_grant[%0d]: got %b want %b", c, request_ready, order[c]); end
      tick();
    end
    idle(); rob_read_valid = 1'b1; response_ready = '1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (response_valid !== order[c]) begin fails++; $display("FAIL order_response[%0d]: got %b want %b", c, response_valid, order[c]); end
      tick();
    end
    idle(); #1;
    checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL order_outstanding: got %0d want 0", outstanding); end
  endtask

  task automatic test_non_owner_ready();
    request_valid = 4'b1000; rob_reserve_ready = 1'b1; #1;
    checks++; if (request_ready !== 4'b1000) begin fails++; $display("FAIL nonowner_grant: got %b want 1000", request_ready); end
    tick(); idle();
    rob_read_valid = 1'b1; response_ready = 4'b0111; #1;
    checks++; if (rob_read_ready !== 1'b0) begin fails++; $display("FAIL nonowner_read_ready: got %b want 0", rob_read_ready); end
    checks++; if (response_valid !== 4'b1000) begin fails++; $display("FAIL nonowner_response_valid: got %b want 1000", response_valid); end
    tick(); #1;
    checks++; if (outstanding !== 4'd1) begin fails++; $display("FAIL nonowner_hold: got %0d want 1", outstanding); end
    response_ready = 4'b1111; #1;
    checks++; if (rob_read_ready !== 1'b1) begin fails++; $display("FAIL owner_read_ready: got %b want 1", rob_read_ready); end
    tick(); idle(); #1;
    checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL owner_pop: got %0d want 0", outstanding); end
  endtask

  task automatic test_simultaneous();
    request_valid = 4'b0001; rob_reserve_ready = 1'b1; response_ready = '1;
    for (int c = 0; c < 5; c++) tick();
    #1;
    checks++; if (outstanding !== 4'd5) begin fails++; $display("FAIL simul_setup: got %0d want 5", outstanding); end
    rob_read_valid = 1'b1; #1;
    checks++; if (request_ready !== 4'b0001) begin fails++; $display("FAIL simul_reserve: got %b want 0001", request_ready); end
    checks++; if (rob_read_ready !== 1'b1) begin fails++; $display("FAIL simul_read: got %b want 1", rob_read_ready); end
    tick(); rob_read_valid = 1'b0; #1;
    checks++; if (outstanding !== 4'd5) begin fails++; $display("FAIL simul_outstanding: got %0d want 5", outstanding); end
    for (int c = 0; c < 3; c++) tick();
    #1;
    checks++; if (outstanding !== 4'd8) begin fails++; $display("FAIL simul_full: got %0d want 8", outstanding); end
    rob_read_valid = 1'b1; #1;
    checks++; if (request_ready !== 4'b0000) begin fails++; $display("FAIL full_push_refused: got %b want 0000", request_ready); end
    checks++; if (rob_read_ready !== 1'b1) begin fails++; $display("FAIL full_pop: got %b want 1", rob_read_ready); end
    tick(); rob_read_valid = 1'b0; #1;
    checks++; if (outstanding !== 4'd7) begin fails++; $display("FAIL full_after_pop: got %0d want 7", outstanding); end
    checks++; if (request_ready !== 4'b0001) begin fails++; $display("FAIL full_push_next: got %b want 0001", request_ready); end
    tick(); #1;
    checks++; if (outstanding !== 4'd8) begin fails++; $display("FAIL full_refill: got %0d want 8", outstanding); end
    request_valid = '0; rob_read_valid = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    #1;
    checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL simul_drain: got %0d want 0", outstanding); end
    checks++; if (response_valid !== 4'b0000) begin fails++; $display("FAIL empty_response_valid: got %b want 0000", response_valid); end
    checks++; if (owner_error !== 1'b0) begin fails++; $display("FAIL error_before: got %b want 0", owner_error); end
    tick(); idle(); #1;
    checks++; if (owner_error !== 1'b1) begin fails++; $display("FAIL owner_error_set: got %b want 1", owner_error); end
    checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL error_no_pop: got %0d want 0", outstanding); end
  endtask

`ifdef REORDER_BUFFER_SCHEDULER_QUOTA_EN
  task automatic test_quota();
    request_valid = 4'b0001; rob_reserve_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (request_ready !== 4'b0001) begin fails++; $display("FAIL quota_grant[%0d]: got %b want 0001", c, request_ready); end
      tick();
    end
    #1;
    checks++; if (request_ready !== 4'b0000) begin fails++; $display("FAIL quota_masked: got %b want 0000", request_ready); end
    checks++; if (rob_reserve_valid !== 1'b0) begin fails++; $display("FAIL quota_reserve_valid: got %b want 0", rob_reserve_valid); end
    request_valid = 4'b0011; #1;
    checks++; if (request_ready !== 4'b0010) begin fails++; $display("FAIL quota_other: got %b want 0010", request_ready); end
    tick();
    request_valid = 4'b0001; rob_read_valid = 1'b1; response_ready = 4'b0001; #1;
    checks++; if (response_valid !== 4'b0001) begin fails++; $display("FAIL quota_read: got %b want 0001", response_valid); end
    checks++; if (request_ready !== 4'b0000) begin fails++; $display("FAIL quota_still_masked: got %b want 0000", request_ready); end
    tick(); rob_read_valid = 1'b0; #1;
    checks++; if (request_ready !== 4'b0001) begin fails++; $display("FAIL quota_released: got %b want 0001", request_ready); end
    tick(); idle();
  endtask
`endif

  task automatic test_reset_midrun();
    request_valid = 4'b0110; rob_reserve_ready = 1'b1; #1;
    checks++; if (request_ready !== 4'b0010) begin fails++; $display("FAIL midrun_grant1: got %b want 0010", request_ready); end
    tick(); #1;
    checks++; if (request_ready !== 4'b0100) begin fails++; $display("FAIL midrun_grant2: got %b want 0100", request_ready); end
    tick();
    reset = 1'b1; request_valid = 4'hF; #1;
    checks++; if (request_ready !== 4'b0000) begin fails++; $display("FAIL midrun_reset_ready: got %b want 0000", request_ready); end
    tick();
    reset = 1'b0; #1;
    checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL midrun_outstanding: got %0d want 0", outstanding); end
    checks++; if (owner_error !== 1'b0) begin fails++; $display("FAIL midrun_owner_error: got %b want 0", owner_error); end
    checks++; if (request_ready !== 4'b0001) begin fails++; $display("FAIL midrun_first_grant: got %b want 0001", request_ready); end
    tick();
    request_valid = '0; rob_read_valid = 1'b1; response_ready = '1; #1;
    checks++; if (response_valid !== 4'b0001) begin fails++; $display("FAIL midrun_owner: got %b want 0001", response_valid); end
    tick(); idle(); #1;
    checks++; if (outstanding !== 4'd0) begin fails++; $display("FAIL midrun_final: got %0d want 0", outstanding); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_fill_and_drain();
    test_stalled_grant();
    test_in_order_response();
    test_non_owner_ready();
    test_simultaneous();
`ifdef REORDER_BUFFER_SCHEDULER_QUOTA_EN
    test_quota();
`endif
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
